cfs_apb_slave_bridge: RTL and testbench

//  APB3 slave front-end: consumes APB transfers from the bus (the same signal set the APB

---
 rtl/cfs_apb_slave_bridge.sv | 137 +++++++++++++
 tb/tb_cfs_apb_slave_bridge.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cfs_apb_slave_bridge.sv
// APB3 slave front-end: turns each APB transfer into one req/ack register-file access,
// inserting wait states until the register side answers or the access times out.
module cfs_apb_slave_bridge #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int TIMEOUT     = 15,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic                  pwrite,
   input  logic                  psel,
   input  logic                  penable,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic                  pready,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pslverr,
   output logic                  reg_req,
   output logic                  reg_wr,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   input  logic                  reg_ack,
   input  logic [DATA_WIDTH-1:0] reg_rdata,
   input  logic                  reg_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

   typedef struct packed {
      logic                  wr;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } acc_t;

   state_e                state_q, state_d;
   acc_t                  acc_q, acc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  req_q, req_d;
   logic                  rdy_q, rdy_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic setup, misalign, tmo_hit;

   assign setup    = psel & ~penable;
   assign misalign = ALIGN_CHECK && (paddr[1:0] != 2'b00);
   // Last REQ cycle: if no ack arrives on this edge the access is abandoned.
   assign tmo_hit  = (cnt_q == CNT_LAST);

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (setup) state_d = misalign ? RESP : REQ;
         REQ: begin
            if (!psel)                  state_d = IDLE;
            else if (reg_ack || tmo_hit) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = '0;
      req_d   = 1'b0;
      rdy_d   = 1'b0;
      err_d   = 1'b0;
      rdata_d = '0;
      case (state_q)
         IDLE: begin
            if (setup) begin
               acc_d = '{wr: pwrite, addr: paddr, wdata: pwdata};
               if (misalign) begin
                  rdy_d = 1'b1;
                  err_d = 1'b1;
               end else begin
                  req_d = 1'b1;
               end
            end
         end
         REQ: begin
            // A dropped psel aborts silently; ack takes priority over timeout.
            if (psel) begin
               if (reg_ack) begin
                  rdy_d   = 1'b1;
                  err_d   = reg_err;
                  rdata_d = (!acc_q.wr && !reg_err) ? reg_rdata : '0;
               end else if (tmo_hit) begin
                  rdy_d = 1'b1;
                  err_d = 1'b1;
               end else begin
                  req_d = 1'b1;
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign pready    = rdy_q;
   assign pslverr   = err_q;
   assign prdata    = rdata_q;
   assign reg_req   = req_q;
   assign reg_wr    = acc_q.wr;
   assign reg_addr  = acc_q.addr;
   assign reg_wdata = acc_q.wdata;

endmodule

// File: tb/tb_cfs_apb_slave_bridge.sv
// Bench for cfs_apb_slave_bridge: directed vector table, hand-written corner sequences,
// and random transfers checked against a transfer-level response model.
module tb_cfs_apb_slave_bridge;

   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int TMO = 15;

   logic          pclk = 1'b0;
   logic          preset_n;
   logic [AW-1:0] paddr;
   logic          pwrite, psel, penable;
   logic [DW-1:0] pwdata;
   logic          pready, pslverr;
   logic [DW-1:0] prdata;
   logic          reg_req, reg_wr;
   logic [AW-1:0] reg_addr;
   logic [DW-1:0] reg_wdata;
   logic          reg_ack, reg_err;
   logic [DW-1:0] reg_rdata;

   int checks = 0;
   int errors = 0;

   cfs_apb_slave_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO), .ALIGN_CHECK(1'b1)) dut (
      .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pwrite(pwrite), .psel(psel),
      .penable(penable), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
      .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
   );

   always #5 pclk = ~pclk;

   // dly: cycles after T1 at which reg_ack is given (>= TMO means never acked)
   typedef struct {
      logic [AW-1:0] addr;
      logic          wr;
      logic [DW-1:0] wdata;
      int            dly;
      logic          err;
      logic [DW-1:0] rdata;
      int            exp_waits;
      logic          exp_err;
      logic [DW-1:0] exp_rdata;
      int            exp_reqs;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Transfer-level response: zero-wait error if misaligned, else answer one cycle
   // after the ack, or an error after TMO request cycles if no ack comes in time.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      if (v.addr % 4 != 0) begin
         r.exp_waits = 0; r.exp_err = 1'b1; r.exp_rdata = '0; r.exp_reqs = 0;
      end else if (v.dly < TMO) begin
         r.exp_waits = v.dly + 1;
         r.exp_err   = v.err;
         r.exp_rdata = (!v.wr && !v.err) ? v.rdata : '0;
         r.exp_reqs  = v.dly + 1;
      end else begin
         r.exp_waits = TMO; r.exp_err = 1'b1; r.exp_rdata = '0; r.exp_reqs = TMO;
      end
      return r;
   endfunction

   // Called at posedge+1 of the cycle that becomes the setup phase T0.
   task automatic xfer(input vec_t v, input string tag);
      int   reqs = 0;
      int   bad  = 0;
      int   waits = -1;
      logic got = 1'b0;
      logic gerr = 1'b0;
      logic greq = 1'b0;
      logic [DW-1:0] grd = '0;
      psel = 1'b1; penable = 1'b0; paddr = v.addr; pwrite = v.wr; pwdata = v.wdata;
      reg_ack = 1'b0;
      for (int n = 1; n <= 40 && !got; n++) begin
         @(posedge pclk); #1;
         penable   = 1'b1;
         reg_ack   = 1'b0;
         reg_err   = 1'($urandom);
         reg_rdata = $urandom;
         if (pready) begin
            got = 1'b1; waits = n - 1; gerr = pslverr; grd = prdata; greq = reg_req;
         end else if (reg_req) begin
            reqs++;
            if (reg_addr !== v.addr || reg_wr !== v.wr || reg_wdata !== v.wdata) bad++;
            if (n - 1 == v.dly) begin
               reg_ack = 1'b1; reg_err = v.err; reg_rdata = v.rdata;
            end
         end
      end
      if (!got) begin
         chk($sformatf("%s.pready_timeout", tag), 32'(got), 32'(1));
      end else begin
         chk($sformatf("%s.waits", tag),   32'(waits), 32'(v.exp_waits));
         chk($sformatf("%s.pslverr", tag), 32'(gerr),  32'(v.exp_err));
         chk($sformatf("%s.prdata", tag),  grd,        v.exp_rdata);
         chk($sformatf("%s.reqs", tag),    32'(reqs),  32'(v.exp_reqs));
         chk($sformatf("%s.req_at_rdy", tag), 32'(greq), 32'(0));
         chk($sformatf("%s.req_fields", tag), 32'(bad), 32'(0));
      end
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; reg_ack = 1'b0;
      chk($sformatf("%s.post_pready", tag),  32'(pready),  32'(0));
      chk($sformatf("%s.post_pslverr", tag), 32'(pslverr), 32'(0));
      chk($sformatf("%s.post_prdata", tag),  prdata,       32'(0));
   endtask

   initial begin
      vec_t v;
      tbl[0] = '{16'h0010, 1'b1, 32'hDEADBEEF, 0,   1'b0, 32'h0,         1,  1'b0, 32'h0,         1};
      tbl[1] = '{16'h0004, 1'b0, 32'h0,        3,   1'b0, 32'h12345678,  4,  1'b0, 32'h12345678,  4};
      tbl[2] = '{16'h0006, 1'b0, 32'h0,        0,   1'b0, 32'h55555555,  0,  1'b1, 32'h0,         0};
      tbl[3] = '{16'h0040, 1'b1, 32'hCAFEF00D, 99,  1'b0, 32'h0,         15, 1'b1, 32'h0,         15};
      tbl[4] = '{16'h0008, 1'b0, 32'h0,        1,   1'b1, 32'hFFFFFFFF,  2,  1'b1, 32'h0,         2};
      tbl[5] = '{16'h000C, 1'b1, 32'h01020304, 0,   1'b0, 32'h0,         1,  1'b0, 32'h0,         1};
      tbl[6] = '{16'h0020, 1'b0, 32'h0,        14,  1'b0, 32'hA5A5A5A5,  15, 1'b0, 32'hA5A5A5A5,  15};
      tbl[7] = '{16'h0013, 1'b1, 32'h77777777, 0,   1'b0, 32'h0,         0,  1'b1, 32'h0,         0};

      preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
      #12;
      chk("rst.pready",  32'(pready),  32'(0));
      chk("rst.pslverr", 32'(pslverr), 32'(0));
      chk("rst.reg_req", 32'(reg_req), 32'(0));
      chk("rst.reg_wr",  32'(reg_wr),  32'(0));
      chk("rst.prdata",  prdata,       32'(0));
      chk("rst.reg_addr", 32'(reg_addr), 32'(0));
      @(posedge pclk); #1;
      preset_n = 1'b1;

      // Stray acks while idle must be ignored.
      reg_ack = 1'b1; reg_err = 1'b1; reg_rdata = 32'hBAD0BAD0;
      for (int i = 0; i < 3; i++) begin
         @(posedge pclk); #1;
         chk("idle_ack.pready",  32'(pready),  32'(0));
         chk("idle_ack.reg_req", 32'(reg_req), 32'(0));
      end
      reg_ack = 1'b0;

      // Directed table, applied back to back.
      for (int i = 0; i < 8; i++) xfer(tbl[i], $sformatf("vec%0d", i));

      // Master drops psel during REQ: silent abort, then a full timeout must still take TMO.
      psel = 1'b1; penable = 1'b0; paddr = 16'h0030; pwrite = 1'b0;
      @(posedge pclk); #1;
      chk("abort.req_T1", 32'(reg_req), 32'(1));
      for (int i = 0; i < 4; i++) begin
         penable = 1'b1;
         @(posedge pclk); #1;
      end
      psel = 1'b0; penable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge pclk); #1;
         chk("abort.reg_req", 32'(reg_req), 32'(0));
         chk("abort.pready",  32'(pready),  32'(0));
      end
      v = '{16'h0034, 1'b1, 32'h0BADCAFE, 99, 1'b0, 32'h0, 0, 1'b0, 32'h0, 0};
      xfer(model(v), "after_abort");

      // Asynchronous reset while in REQ.
      psel = 1'b1; penable = 1'b0; paddr = 16'h0ABC; pwrite = 1'b1; pwdata = 32'h13572468;
      @(posedge pclk); #1;
      penable = 1'b1;
      chk("rstreq.reg_req", 32'(reg_req), 32'(1));
      #2 preset_n = 1'b0;
      #1;
      chk("rstreq.reg_req",   32'(reg_req),   32'(0));
      chk("rstreq.reg_wr",    32'(reg_wr),    32'(0));
      chk("rstreq.reg_addr",  32'(reg_addr),  32'(0));
      chk("rstreq.reg_wdata", reg_wdata,      32'(0));
      chk("rstreq.pready",    32'(pready),    32'(0));
      chk("rstreq.pslverr",   32'(pslverr),   32'(0));
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      preset_n = 1'b1;
      @(posedge pclk); #1;
      v = '{16'h0100, 1'b0, 32'h0, 2, 1'b0, 32'h89ABCDEF, 0, 1'b0, 32'h0, 0};
      xfer(model(v), "after_rst");

      // Random transfers against the transfer-level model.
      for (int i = 0; i < 40; i++) begin
         v.addr = 16'($urandom);
         if ($urandom_range(3) != 0) v.addr[1:0] = 2'b00;
         v.wr    = 1'($urandom);
         v.wdata = $urandom;
         v.dly   = int'($urandom_range(TMO + 2));
         v.err   = ($urandom_range(3) == 0);
         v.rdata = $urandom;
         xfer(model(v), $sformatf("rnd%0d", i));
         if ($urandom_range(1) == 1) begin
            @(posedge pclk); #1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
